// File: rtl/uart_fifo_core.sv
// uart_fifo_core: 16x-oversampled UART with TX/RX FIFOs.
// Parity and stop-bit count are selected at run time. Error flags are sticky.

// First-word-fall-through circular buffer with an occupancy counter.
module uart_fifo_core_buf #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer still lands when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage array; contents are only observed through the level-gated head
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally at depth; level tracks occupancy
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_fifo_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned BAUD_W     = 13
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [BAUD_W-1:0]     BAUD_VAL,
  input  logic                  PARITY_EN,
  input  logic                  ODD_N_EVEN,
  input  logic                  STOP2,
  input  logic                  TX_WE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  RX_RE,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  CLR_ERR,
  output logic                  TXRDY,
  output logic                  RXRDY,
  output logic                  TX_IDLE,
  output logic [FIFO_AW:0]      TX_LEVEL,
  output logic [FIFO_AW:0]      RX_LEVEL,
  output logic                  PARITY_ERR,
  output logic                  FRAMING_ERR,
  output logic                  OVERFLOW,
  input  logic                  RX,
  output logic                  TX
);
  typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PARITY, TXS_STOP} tx_state_t;
  typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_PARITY, RXS_STOP} rx_state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic              tick;

  logic                  tx_pop, tx_empty, tx_full;
  logic [DATA_WIDTH-1:0] tx_head;
  tx_state_t             tx_state, tx_state_n;
  logic [4:0]            tx_cnt, tx_cnt_n;
  logic [3:0]            tx_bit, tx_bit_n;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n;
  logic                  tx_par, tx_par_n, tx_pen, tx_pen_n, tx_stop2, tx_stop2_n;
  logic                  tx_q, tx_n;

  logic [1:0]            rx_sync;
  logic                  rx_s;
  logic                  rx_push, rx_empty, rx_full;
  rx_state_t             rx_state, rx_state_n;
  logic [3:0]            rx_cnt, rx_cnt_n;
  logic [3:0]            rx_bit, rx_bit_n;
  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_n;
  logic                  rx_parbit, rx_parbit_n;
  logic                  set_fe, set_pe, set_ov;

  uart_fifo_core_buf #(.W(DATA_WIDTH), .AW(FIFO_AW)) u_tx_fifo (
    .CLK(CLK), .RESET(RESET), .push(TX_WE), .din(TX_DATA), .pop(tx_pop),
    .dout(tx_head), .level(TX_LEVEL), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_core_buf #(.W(DATA_WIDTH), .AW(FIFO_AW)) u_rx_fifo (
    .CLK(CLK), .RESET(RESET), .push(rx_push), .din(rx_sh), .pop(RX_RE),
    .dout(RX_DATA), .level(RX_LEVEL), .full(rx_full), .empty(rx_empty)
  );

  assign tick    = (baud_cnt == '0);
  assign TXRDY   = !tx_full;
  assign RXRDY   = !rx_empty;
  assign TX_IDLE = tx_empty && (tx_state == TXS_IDLE);
  assign TX      = tx_q;
  assign rx_s    = rx_sync[1];

  // oversample tick: down-counter reloaded from BAUD_VAL on each tick
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     baud_cnt <= '0;
    else if (tick) baud_cnt <= BAUD_VAL;
    else           baud_cnt <= baud_cnt - 1'b1;
  end

  // TX state, shifter and registered line output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_state <= TXS_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_pen   <= tx_pen_n;
      tx_stop2 <= tx_stop2_n;
      tx_q     <= tx_n;
    end
  end

  // TX next state: frame format is latched at the pop so mid-frame changes are harmless
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_pen_n   = tx_pen;
    tx_stop2_n = tx_stop2;
    tx_n       = tx_q;
    tx_pop     = 1'b0;
    if (tick) begin
      case (tx_state)
        TXS_IDLE: begin
          tx_n = 1'b1;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_par_n   = (^tx_head) ^ ODD_N_EVEN;
            tx_pen_n   = PARITY_EN;
            tx_stop2_n = STOP2;
            tx_cnt_n   = '0;
            tx_state_n = TXS_START;
            tx_n       = 1'b0;
          end
        end
        TXS_START: begin
          if (tx_cnt == 5'd15) begin
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_state_n = TXS_DATA;
            tx_n       = tx_sh[0];
          end else tx_cnt_n = tx_cnt + 1'b1;
        end
        TXS_DATA: begin
          if (tx_cnt == 5'd15) begin
            tx_cnt_n = '0;
            if (tx_bit == LAST_BIT) begin
              tx_state_n = tx_pen ? TXS_PARITY : TXS_STOP;
              tx_n       = tx_pen ? tx_par : 1'b1;
            end else begin
              tx_bit_n = tx_bit + 1'b1;
              tx_sh_n  = tx_sh >> 1;
              tx_n     = tx_sh[1];
            end
          end else tx_cnt_n = tx_cnt + 1'b1;
        end
        TXS_PARITY: begin
          if (tx_cnt == 5'd15) begin
            tx_cnt_n   = '0;
            tx_state_n = TXS_STOP;
            tx_n       = 1'b1;
          end else tx_cnt_n = tx_cnt + 1'b1;
        end
        TXS_STOP: begin
          if (tx_cnt == (tx_stop2 ? 5'd31 : 5'd15)) begin
            tx_cnt_n   = '0;
            tx_state_n = TXS_IDLE;
          end else tx_cnt_n = tx_cnt + 1'b1;
        end
        default: tx_state_n = TXS_IDLE;
      endcase
    end
  end

  // RX synchronizer, state and shifter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_sync   <= '1;
      rx_state  <= RXS_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_parbit <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], RX};
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_sh     <= rx_sh_n;
      rx_parbit <= rx_parbit_n;
    end
  end

  // RX next state: start bit checked at half-bit, later bits sampled mid-bit
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_parbit_n = rx_parbit;
    rx_push     = 1'b0;
    set_fe      = 1'b0;
    set_pe      = 1'b0;
    if (tick) begin
      case (rx_state)
        RXS_IDLE: begin
          if (!rx_s) begin
            rx_cnt_n   = '0;
            rx_state_n = RXS_START;
          end
        end
        RXS_START: begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_s ? RXS_IDLE : RXS_DATA;
          end else rx_cnt_n = rx_cnt + 1'b1;
        end
        RXS_DATA: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_s, rx_sh[DATA_WIDTH-1:1]};
            if (rx_bit == LAST_BIT) rx_state_n = PARITY_EN ? RXS_PARITY : RXS_STOP;
            else                    rx_bit_n   = rx_bit + 1'b1;
          end else rx_cnt_n = rx_cnt + 1'b1;
        end
        RXS_PARITY: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n    = '0;
            rx_parbit_n = rx_s;
            rx_state_n  = RXS_STOP;
          end else rx_cnt_n = rx_cnt + 1'b1;
        end
        RXS_STOP: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n   = '0;
            rx_push    = 1'b1;
            set_fe     = !rx_s;
            set_pe     = PARITY_EN && (rx_parbit != ((^rx_sh) ^ ODD_N_EVEN));
            rx_state_n = RXS_IDLE;
          end else rx_cnt_n = rx_cnt + 1'b1;
        end
        default: rx_state_n = RXS_IDLE;
      endcase
    end
  end

  // the character is lost exactly when the RX buffer refuses the push
  assign set_ov = rx_push && rx_full && !RX_RE;

  // sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PARITY_ERR  <= 1'b0;
      FRAMING_ERR <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      if (set_pe)       PARITY_ERR  <= 1'b1;
      else if (CLR_ERR) PARITY_ERR  <= 1'b0;
      if (set_fe)       FRAMING_ERR <= 1'b1;
      else if (CLR_ERR) FRAMING_ERR <= 1'b0;
      if (set_ov)       OVERFLOW    <= 1'b1;
      else if (CLR_ERR) OVERFLOW    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Testbench for uart_fifo_core: TX waveform, loopback, overflow, error flags,
// false start and asynchronous reset abort.
`timescale 1ns/1ps
module tb_uart_fifo_core;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned BW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] baud_val;
  logic          parity_en, odd_n_even, stop2, tx_we, rx_re, clr_err;
  logic [DW-1:0] tx_data, rx_data;
  logic          txrdy, rxrdy, tx_idle, tx, rx_line, rx_drv, loopback;
  logic [AW:0]   tx_level, rx_level;
  logic          parity_err, framing_err, overflow;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] rx_exp_q[$];
  logic          tx_exp_q[$];

  always #5 clk = ~clk;
  assign rx_line = loopback ? tx : rx_drv;

  uart_fifo_core #(.DATA_WIDTH(DW), .FIFO_AW(AW), .BAUD_W(BW)) dut (
    .CLK(clk), .RESET(reset), .BAUD_VAL(baud_val), .PARITY_EN(parity_en),
    .ODD_N_EVEN(odd_n_even), .STOP2(stop2), .TX_WE(tx_we), .TX_DATA(tx_data),
    .RX_RE(rx_re), .RX_DATA(rx_data), .CLR_ERR(clr_err), .TXRDY(txrdy),
    .RXRDY(rxrdy), .TX_IDLE(tx_idle), .TX_LEVEL(tx_level), .RX_LEVEL(rx_level),
    .PARITY_ERR(parity_err), .FRAMING_ERR(framing_err), .OVERFLOW(overflow),
    .RX(rx_line), .TX(tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one RX frame at 16 clocks per bit (BAUD_VAL=0)
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic odd,
                            input logic flip_par, input logic stop_bit);
    rx_drv = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(16);
    end
    if (par_en) begin
      rx_drv = (^d) ^ odd ^ flip_par;
      step(16);
    end
    rx_drv = stop_bit;
    step(16);
    rx_drv = 1'b1;
    step(24);
  endtask

  task automatic read_rx(input string tag);
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (!rxrdy && n < 3000) begin
      step(1);
      n++;
    end
    check_eq({tag, "_rxrdy"}, rxrdy, 1);
    if (rxrdy) begin
      e = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 'x;
      check_eq({tag, "_data"}, rx_data, e);
      rx_re = 1'b1;
      step(1);
      rx_re = 1'b0;
    end
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data = d;
    tx_we   = 1'b1;
    step(1);
    tx_we   = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ov_data [5];
    int lows;
    int n;
    ov_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b1; baud_val = '0; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
    tx_we = 1'b0; tx_data = '0; rx_re = 1'b0; clr_err = 1'b0; rx_drv = 1'b1; loopback = 1'b0;
    step(3);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_txrdy", txrdy, 1);
    check_eq("rst_tx_idle", tx_idle, 1);
    check_eq("rst_rxrdy", rxrdy, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_tx_level", tx_level, 0);
    check_eq("rst_rx_level", rx_level, 0);
    check_eq("rst_errs", {parity_err, framing_err, overflow}, 0);
    reset = 1'b0;
    step(2);

    // single 8N1 frame of 0x55: expected line samples queued as the write is issued
    for (int i = 0; i < 16; i++) tx_exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) tx_exp_q.push_back(b[0] ? 1'b0 : 1'b1);
    for (int i = 0; i < 16; i++) tx_exp_q.push_back(1'b1);
    push_tx(8'h55);
    check_eq("txwe_level", tx_level, 1);
    check_eq("txwe_tx_idle", tx_idle, 0);
    check_eq("txwe_tx_still_high", tx, 1);
    step(1);
    check_eq("pop_level", tx_level, 0);
    while (tx_exp_q.size() != 0) begin
      check_eq("tx_bit", tx, tx_exp_q.pop_front());
      step(1);
    end
    check_eq("tx_done_idle", tx_idle, 1);
    check_eq("tx_done_line", tx, 1);

    // loopback, odd parity, two stop bits, slower tick
    loopback = 1'b1; baud_val = 13'd2; parity_en = 1'b1; odd_n_even = 1'b1; stop2 = 1'b1;
    rx_exp_q.push_back(8'hA5); push_tx(8'hA5);
    rx_exp_q.push_back(8'h00); push_tx(8'h00);
    rx_exp_q.push_back(8'hFF); push_tx(8'hFF);
    read_rx("lb0");
    read_rx("lb1");
    read_rx("lb2");
    n = 0;
    while (!tx_idle && n < 3000) begin
      step(1);
      n++;
    end
    check_eq("lb_tx_idle", tx_idle, 1);
    step(60);
    check_eq("lb_parity_err", parity_err, 0);
    check_eq("lb_framing_err", framing_err, 0);
    check_eq("lb_overflow", overflow, 0);
    loopback = 1'b0; baud_val = '0; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
    step(20);

    // overflow: five characters into a four-entry RX buffer
    for (int k = 0; k < 5; k++) begin
      if (k < 4) rx_exp_q.push_back(ov_data[k]);
      send_frame(ov_data[k], 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("ov_level", rx_level, 4);
    check_eq("ov_flag", overflow, 1);
    for (int k = 0; k < 4; k++) read_rx("ov_rd");
    check_eq("ov_drained", rxrdy, 0);
    check_eq("ov_flag_held", overflow, 1);
    clear_errors();
    check_eq("ov_cleared", overflow, 0);

    // framing error: stop bit forced low, character still stored
    rx_exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fe_flag", framing_err, 1);
    check_eq("fe_no_pe", parity_err, 0);
    read_rx("fe_rd");
    check_eq("fe_no_extra", rxrdy, 0);
    clear_errors();
    check_eq("fe_cleared", framing_err, 0);

    // even parity: good frame, then a frame with the parity bit flipped
    parity_en = 1'b1; odd_n_even = 1'b0;
    rx_exp_q.push_back(8'h5B);
    send_frame(8'h5B, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("pe_good", parity_err, 0);
    read_rx("pe_good_rd");
    rx_exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("pe_flag", parity_err, 1);
    check_eq("pe_no_fe", framing_err, 0);
    read_rx("pe_bad_rd");
    clear_errors();
    check_eq("pe_cleared", parity_err, 0);
    parity_en = 1'b0;

    // false start: short low pulse, then a real frame must still decode
    rx_drv = 1'b0;
    step(4);
    rx_drv = 1'b1;
    step(40);
    check_eq("fs_rxrdy", rxrdy, 0);
    check_eq("fs_level", rx_level, 0);
    rx_exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    read_rx("fs_next");

    // reset during data bit 3 of a frame with two characters still queued
    push_tx(8'hC3);
    push_tx(8'h18);
    push_tx(8'h7E);
    step(68);
    check_eq("mid_level", tx_level, 2);
    reset = 1'b1;
    #1;
    check_eq("arst_tx", tx, 1);
    check_eq("arst_level", tx_level, 0);
    check_eq("arst_txrdy", txrdy, 1);
    check_eq("arst_tx_idle", tx_idle, 1);
    step(2);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (!tx) lows++;
    end
    check_eq("no_residual_frame", lows, 0);
    check_eq("post_rst_idle", tx_idle, 1);
    check_eq("sb_empty", rx_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised next-generation UART core for the APB UART subsystem. It combines a 16x-oversampling baud generator, a transmitter, a receiver, and synchronous TX and RX FIFOs of configurable depth behind a simple active-high strobe interface. Character width is a build-time parameter; parity and stop-bit count are selected at run time. Error flags are sticky, and TX/RX FIFO fill levels are exported so the APB wrapper can drive level interrupts.

## Interface
- DATA_WIDTH, 8, character width in bits; legal values 5..9.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries per direction; legal values 1..8.
- BAUD_W, 13, width of BAUD_VAL.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset; asynchronous and active-high.
- BAUD_VAL  in  BAUD_W  oversample tick period minus 1.
- PARITY_EN  in  1  1 = a parity bit follows the data bits.
- ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity.
- STOP2  in  1  1 = TX sends two stop bits (RX always checks only the first).
- TX_WE  in  1  push TX_DATA into the TX FIFO.
- TX_DATA  in  DATA_WIDTH  character to send.
- RX_RE  in  1  pop the RX FIFO head.
- RX_DATA  out  DATA_WIDTH  RX FIFO head (first-word-fall-through).
- CLR_ERR  in  1  clears all sticky error flags.
- TXRDY  out  1  TX FIFO not full.
- RXRDY  out  1  RX FIFO not empty.
- TX_IDLE  out  1  TX FIFO empty and shifter idle.
- TX_LEVEL, RX_LEVEL  out  FIFO_AW+1  current FIFO occupancy.
- PARITY_ERR, FRAMING_ERR, OVERFLOW  out  1  sticky error flags.
- RX  in  1  serial input (asynchronous).
- TX  out  1  serial output.

## Operation
- Baud generator: down-counter reloaded with BAUD_VAL; emits a one-cycle `tick` when the counter is 0. BAUD_VAL=0 gives a tick every clock. One bit period = 16 ticks.
- FIFOs: circular buffers with a (FIFO_AW+1)-bit level counter.
  - A push when full is dropped; a pop when empty is ignored.
  - Simultaneous push and pop both succeed, leaving the level unchanged (this also holds when full or empty, provided the operation is otherwise legal).
  - Pointers wrap modulo depth.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with the TX FIFO non-empty, pop the head into the shifter and go to START (TX=0).
  - Each state lasts 16 ticks.
  - DATA shifts DATA_WIDTH bits, LSB first.
  - PARITY is skipped when PARITY_EN=0. Parity bit = XOR of the data bits, inverted when ODD_N_EVEN=1.
  - STOP lasts 16 or 32 ticks (STOP2) with TX=1, then returns to IDLE.
  - PARITY_EN, ODD_N_EVEN and STOP2 are sampled at the pop.
- RX path: two-flop synchronizer on RX feeding the FSM (states IDLE, START, DATA, PARITY, STOP).
  - IDLE: a sampled 0 on a tick goes to START.
  - START: after 8 ticks re-sample. If 1, treat as a false start and return to IDLE; if 0, go to DATA.
  - DATA, PARITY and STOP each sample once every 16 ticks (mid-bit).
  - On the STOP sample:
    - push the character into the RX FIFO;
    - set FRAMING_ERR if stop=0;
    - set PARITY_ERR on mismatch (when enabled);
    - if the FIFO is full, discard the character and set OVERFLOW;
    - return to IDLE immediately.
  - Characters with framing or parity errors are still stored.
- Error flags: set-dominant over CLR_ERR in the same cycle.

## Timing
- Reset values:
  - TX=1, TXRDY=1, TX_IDLE=1, RXRDY=0.
  - RX_DATA=0, both levels=0, all error flags=0.
  - Both FSMs in IDLE, baud counter = 0, synchronizer flops = 1.
- RESET asserted mid-frame aborts both frames within the same cycle (asynchronous). TX returns to 1 and FIFO contents are discarded.
- TX_WE in cycle n: TX_LEVEL and TXRDY are updated at n+1. The start bit begins on the first tick after n+1 (with BAUD_VAL=0: TX falls at n+2).
- RX push: RXRDY, RX_LEVEL and RX_DATA are valid in the cycle after the STOP sample. Error flags update in that same cycle.
- RX_RE in cycle n: the next head appears on RX_DATA at n+1.
- RX latency: with BAUD_VAL=0, an ideal 8N1 frame is pushed 8+16·9 = 152 clocks after the first synchronized low, plus 2 clocks of synchronizer delay.
- BAUD_VAL changes take effect at the next reload.

## Test plan
- Single TX frame: BAUD_VAL=0, 8N1, TX_WE with 0x55.
  - TX low for 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high for 16 clocks; TX_IDLE=1 afterwards.
- Loopback TX→RX, odd parity, STOP2=1: send 0xA5, 0x00, 0xFF.
  - RXRDY=1 and RX_DATA reads back 0xA5, 0x00, 0xFF in order; no error flags.
- RX overflow: FIFO_AW=2, send 5 characters with no RX_RE.
  - RX_LEVEL=4 and OVERFLOW=1; the first 4 characters read back in order; CLR_ERR clears OVERFLOW.
- RX errors:
  - Frame 0x3C with stop bit forced to 0 → FRAMING_ERR=1 and 0x3C is stored.
  - Even-parity frame with the parity bit flipped → PARITY_ERR=1.
- False start: RX low for 4 ticks, then high → no push, RXRDY stays 0, RX FSM back in IDLE.
- Reset mid-frame: assert RESET at bit 3 of a TX frame with TX_LEVEL=2.
  - Immediately TX=1, TX_LEVEL=0, TXRDY=1.
  - After release, no residual frame is transmitted.
